// File: rtl/op_bus_pkg.sv
// Shared types for the 2-bit command/address register bus initiator.
// Bus command encodings, register map and sequencer states.
package op_bus_pkg;

   typedef enum logic [1:0] {
      CMD_IDLE = 2'b00,
      CMD_WR   = 2'b01,
      CMD_RD   = 2'b10
   } cmd_t;

   localparam logic [1:0] ADDR_START = 2'b00;
   localparam logic [1:0] ADDR_A     = 2'b01;
   localparam logic [1:0] ADDR_B     = 2'b10;
   localparam logic [1:0] ADDR_CTRL  = 2'b11;

   typedef enum logic [3:0] {
      IDLE,
      WR_A,
      WR_B,
      WR_CTRL,
      WR_START,
      WAIT_DONE,
      RD,
      RD_CAP,
      RESP
   } state_t;

endpackage

// File: rtl/op_timeout_cnt.sv
// 8-bit wait counter with synchronous clear and a terminal-count flag.
// Saturates at the terminal value so the flag stays asserted.
module op_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   logic [7:0] count;

   assign tc = (count == 8'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !tc) begin
         count <= count + 8'd1;
      end
   end

endmodule

// File: rtl/op_seq_master.sv
// Register-bus initiator: writes operands, starts the slave, waits for
// done (bounded), reads the result back and hands it to the user.
module op_seq_master
   import op_bus_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DATA_WIDTH-1:0] req_a,
   input  logic [DATA_WIDTH-1:0] req_b,
   input  logic [DATA_WIDTH-1:0] req_ctrl,
   output logic [1:0]            Rd_Wr_Id,
   output logic [1:0]            addres,
   output logic [DATA_WIDTH-1:0] wr_data,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  operation_done,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  resp_timeout
);

   state_t                state;
   logic [DATA_WIDTH-1:0] b_q;
   logic [DATA_WIDTH-1:0] ctrl_q;
   logic                  in_wait;
   logic                  tc;

   assign in_wait = (state == WAIT_DONE);

   // Counter is held clear outside WAIT_DONE, so it starts at 0 on entry.
   op_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (!in_wait),
      .enable (in_wait),
      .tc     (tc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         req_ready    <= 1'b1;
         Rd_Wr_Id     <= CMD_IDLE;
         addres       <= ADDR_START;
         wr_data      <= '0;
         resp_valid   <= 1'b0;
         resp_data    <= '0;
         resp_timeout <= 1'b0;
         b_q          <= '0;
         ctrl_q       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  b_q       <= req_b;
                  ctrl_q    <= req_ctrl;
                  req_ready <= 1'b0;
                  Rd_Wr_Id  <= CMD_WR;
                  addres    <= ADDR_A;
                  wr_data   <= req_a;
                  state     <= WR_A;
               end
            end
            WR_A: begin
               addres  <= ADDR_B;
               wr_data <= b_q;
               state   <= WR_B;
            end
            WR_B: begin
               addres  <= ADDR_CTRL;
               wr_data <= ctrl_q;
               state   <= WR_CTRL;
            end
            WR_CTRL: begin
               addres  <= ADDR_START;
               wr_data <= '0;
               state   <= WR_START;
            end
            WR_START: begin
               Rd_Wr_Id <= CMD_IDLE;
               addres   <= ADDR_START;
               wr_data  <= '0;
               state    <= WAIT_DONE;
            end
            WAIT_DONE: begin
               // Done takes priority over an expiring timeout.
               if (operation_done) begin
                  Rd_Wr_Id <= CMD_RD;
                  addres   <= ADDR_START;
                  state    <= RD;
               end else if (tc) begin
                  resp_valid   <= 1'b1;
                  resp_data    <= '0;
                  resp_timeout <= 1'b1;
                  state        <= RESP;
               end
            end
            RD: begin
               Rd_Wr_Id <= CMD_IDLE;
               state    <= RD_CAP;
            end
            RD_CAP: begin
               resp_valid   <= 1'b1;
               resp_data    <= rd_data;
               resp_timeout <= 1'b0;
               state        <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               Rd_Wr_Id  <= CMD_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_op_seq_master.sv
// Self-checking bench: table of requests against a slave model, with a
// bus-command scoreboard and a response scoreboard.
module tb_op_seq_master;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [7:0] req_a = '0;
   logic [7:0] req_b = '0;
   logic [7:0] req_ctrl = '0;
   logic [1:0] Rd_Wr_Id;
   logic [1:0] addres;
   logic [7:0] wr_data;
   logic [7:0] rd_data;
   logic       operation_done;
   logic       resp_valid;
   logic       resp_ready = 1'b0;
   logic [7:0] resp_data;
   logic       resp_timeout;

   op_seq_master #(
      .DATA_WIDTH(8),
      .TIMEOUT_CYCLES(15)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_a          (req_a),
      .req_b          (req_b),
      .req_ctrl       (req_ctrl),
      .Rd_Wr_Id       (Rd_Wr_Id),
      .addres         (addres),
      .wr_data        (wr_data),
      .rd_data        (rd_data),
      .operation_done (operation_done),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_data      (resp_data),
      .resp_timeout   (resp_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] ctrl;
      int         delay;
      int         hold;
      bit         stray;
      logic [7:0] exp_data;
      bit         exp_tmo;
      int         exp_lat;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      bit         tmo;
      int         lat;
   } resp_t;

   typedef struct {
      logic [1:0] cmd;
      logic [1:0] addr;
      logic [7:0] data;
      int         cyc;
   } bus_t;

   int    nvec = 0;
   int    nfail = 0;
   int    cyc = 0;
   resp_t resp_q[$];
   bus_t  bus_q[$];
   bus_t  mon_item;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, got, exp, cyc);
      end
   endtask

   // Slave model: done pulse 'cfg_delay' WAIT_DONE cycles after the start
   // write (0 = never); result is a+b when ctrl[0] is set, else a^b.
   int         cfg_delay = 1;
   int         dcnt;
   logic [7:0] s_a, s_b, s_c;
   logic       slave_done;
   logic       stray_done = 1'b0;

   assign operation_done = slave_done | stray_done;

   function automatic logic [7:0] slave_fn(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [7:0] c);
      return c[0] ? 8'(a + b) : (a ^ b);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_a <= '0; s_b <= '0; s_c <= '0;
         dcnt <= 0;
         slave_done <= 1'b0;
         rd_data <= '0;
      end else begin
         slave_done <= 1'b0;
         if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) slave_done <= 1'b1;
         end
         if (Rd_Wr_Id == 2'b01) begin
            case (addres)
               2'b01: s_a <= wr_data;
               2'b10: s_b <= wr_data;
               2'b11: s_c <= wr_data;
               default: begin
                  if (cfg_delay == 1) slave_done <= 1'b1;
                  else if (cfg_delay > 1) dcnt <= cfg_delay - 1;
               end
            endcase
         end
         if (Rd_Wr_Id == 2'b10) rd_data <= slave_fn(s_a, s_b, s_c);
      end
   end

   // Bus monitor: every non-idle command must match the next expected one.
   always @(negedge clk) begin
      if (rst && Rd_Wr_Id != 2'b00) begin
         if (bus_q.size() == 0) begin
            chk("bus_unexpected", {28'd0, Rd_Wr_Id, addres}, 32'd0);
         end else begin
            mon_item = bus_q.pop_front();
            chk("bus_cmd", {30'd0, Rd_Wr_Id}, {30'd0, mon_item.cmd});
            chk("bus_addr", {30'd0, addres}, {30'd0, mon_item.addr});
            chk("bus_data", {24'd0, wr_data}, {24'd0, mon_item.data});
            chk("bus_cycle", cyc, mon_item.cyc);
         end
      end
   end

   task automatic push_bus(input logic [1:0] cmd, input logic [1:0] addr,
                           input logic [7:0] data, input int c);
      bus_t it;
      it.cmd = cmd; it.addr = addr; it.data = data; it.cyc = c;
      bus_q.push_back(it);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      chk({tag, "_cmd"}, {30'd0, Rd_Wr_Id}, 32'd0);
      chk({tag, "_addr"}, {30'd0, addres}, 32'd0);
      chk({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
      chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, "_resp_data"}, {24'd0, resp_data}, 32'd0);
      chk({tag, "_resp_timeout"}, {31'd0, resp_timeout}, 32'd0);
   endtask

   task automatic run_vec(input vec_t v);
      resp_t er;
      int    t_acc;
      int    lat;
      bit    seen;
      @(negedge clk);
      req_a = v.a; req_b = v.b; req_ctrl = v.ctrl;
      cfg_delay = v.delay;
      req_valid = 1'b1;
      er.data = v.exp_data; er.tmo = v.exp_tmo; er.lat = v.exp_lat;
      resp_q.push_back(er);
      @(posedge clk); #1;
      t_acc = cyc;
      req_valid = 1'b0;
      req_a = ~v.a; req_b = ~v.b; req_ctrl = ~v.ctrl;
      push_bus(2'b01, 2'b01, v.a, t_acc);
      push_bus(2'b01, 2'b10, v.b, t_acc + 1);
      push_bus(2'b01, 2'b11, v.ctrl, t_acc + 2);
      push_bus(2'b01, 2'b00, 8'h00, t_acc + 3);
      if (!v.exp_tmo) push_bus(2'b10, 2'b00, 8'h00, t_acc + v.exp_lat - 2);
      chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
      seen = 1'b0;
      lat = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         if (resp_valid) begin
            seen = 1'b1;
            lat = cyc - t_acc;
         end
      end
      er = resp_q.pop_front();
      if (!seen) begin
         chk("resp_wait_expired", 32'd0, 32'd1);
      end else begin
         chk("resp_data", {24'd0, resp_data}, {24'd0, er.data});
         chk("resp_timeout", {31'd0, resp_timeout}, {31'd0, er.tmo});
         chk("resp_latency", lat, er.lat);
         for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            if (v.stray) begin
               stray_done = 1'b1;
               req_valid = 1'b1;
            end
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_data", {24'd0, resp_data}, {24'd0, er.data});
            chk("hold_tmo", {31'd0, resp_timeout}, {31'd0, er.tmo});
         end
         @(negedge clk);
         stray_done = 1'b0;
         req_valid = 1'b0;
         resp_ready = 1'b1;
         @(posedge clk); #1;
         chk("post_resp_valid", {31'd0, resp_valid}, 32'd0);
         chk("post_req_ready", {31'd0, req_ready}, 32'd1);
         @(negedge clk);
         resp_ready = 1'b0;
      end
      chk("bus_pending", bus_q.size(), 32'd0);
      bus_q.delete();
   endtask

   vec_t tbl[7];
   vec_t v2;

   initial begin
      tbl[0] = '{8'h12, 8'h34, 8'h05, 1,  0,  1'b0, 8'h46, 1'b0, 7};
      tbl[1] = '{8'hff, 8'h01, 8'h01, 2,  2,  1'b0, 8'h00, 1'b0, 8};
      tbl[2] = '{8'ha5, 8'h5a, 8'h02, 1,  10, 1'b1, 8'hff, 1'b0, 7};
      tbl[3] = '{8'h3c, 8'h0f, 8'h00, 0,  1,  1'b0, 8'h00, 1'b1, 19};
      tbl[4] = '{8'h10, 8'h20, 8'h01, 15, 0,  1'b0, 8'h30, 1'b0, 21};
      tbl[5] = '{8'h80, 8'h80, 8'h00, 16, 2,  1'b0, 8'h00, 1'b1, 19};
      tbl[6] = '{8'h77, 8'h11, 8'h03, 3,  3,  1'b1, 8'h88, 1'b0, 9};

      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("in_reset");
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("after_reset");

      foreach (tbl[i]) run_vec(tbl[i]);

      // Reset while WR_B is on the bus.
      @(negedge clk);
      req_a = 8'h21; req_b = 8'h43; req_ctrl = 8'h01;
      cfg_delay = 1;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      push_bus(2'b01, 2'b01, 8'h21, cyc);
      @(posedge clk); #1;
      chk("midrst_wr_b_cmd", {30'd0, Rd_Wr_Id}, 32'd1);
      chk("midrst_wr_b_addr", {30'd0, addres}, 32'd2);
      #1 rst = 1'b0;
      #1;
      check_idle_outputs("midrst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("midrst_bus_pending", bus_q.size(), 32'd0);
      chk("midrst_idle_cmd", {30'd0, Rd_Wr_Id}, 32'd0);
      bus_q.delete();

      v2 = '{8'h21, 8'h43, 8'h01, 1, 0, 1'b0, 8'h64, 1'b0, 7};
      run_vec(v2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
